usb_utm_tx: RTL and testbench
=============================

# usb_utm_tx

Parametrised UTMI transmit engine for the full-speed USB device core, replacing the fixed 8-bit transmit path of the UTM. It accepts packet data over an 8- or 16-bit UTMI handshake and serialises it with SYNC, bit stuffing, NRZI encoding and EOP. It drives the FS line at one bit per CLK_PER_BIT system clocks and honours the UTMI operational modes.

## Interface
- DATA_W, 8: UTMI data width; legal values are 8 or 16.
- CLK_PER_BIT, 4: system clocks per FS bit; must be ≥2.
- clk in 1: system clock.
- rst in 1: reset, asynchronous, active-low.
- op_mode in utm_op_mode_t: 0 NORMAL, 1 NON_DRIVING, 2 DISABLE_BITSTUFF_NRZI.
- data_in in DATA_W: transmit data, LSB first; the low byte is sent first.
- tx_valid in 1: data_in is valid; deasserting it ends the packet.
- tx_valid_h in 1: high byte of data_in is valid. Ignored when DATA_W=8.
- tx_ready out 1: one-cycle pulse; data_in is captured on this edge.
- tx_active out 1: high from the first SYNC bit through the end of EOP J.
- usb_dp_tx out 1: D+ drive value.
- usb_dn_tx out 1: D− drive value.
- usb_tx_oen out 1: output enable, active-low (0 = driving).

## Operation
- Line states: J = (dp 1, dn 0); K = (0, 1); SE0 = (0, 0).
- Reset values: tx_ready 0, tx_active 0, usb_tx_oen 1, usb_dp_tx 1, usb_dn_tx 0, FSM IDLE, bit counter 0, ones counter 0.
- FSM states: IDLE → SYNC → DATA → EOP_SE0 → EOP_J → IDLE.
- IDLE:
  - Outputs J with usb_tx_oen=1.
  - tx_valid=1 with op_mode≠NON_DRIVING moves to SYNC.
  - op_mode is latched at this transition; later changes are ignored until the next IDLE.
- NON_DRIVING: FSM stays in IDLE; tx_valid is ignored; tx_ready stays 0.
- SYNC:
  - Sends 8 bits of 0x80, LSB first; with NRZI from J this gives KJKJKJKK.
  - The ones counter starts at 0 and counts the trailing SYNC 1.
- DATA, NORMAL mode:
  - Each bit passes through stuffing, then NRZI (0 toggles the line, 1 holds it).
  - After 6 consecutive 1s, a 0 is inserted and the ones counter clears; a data 0 also clears it.
  - A stuff bit owed after the final data bit is still sent before EOP.
- DATA, DISABLE_BITSTUFF_NRZI mode: each bit drives directly, 1 = J and 0 = K. No stuffing. SYNC and EOP are unchanged.
- 16-bit words:
  - tx_ready pulses once per word.
  - With tx_valid_h=1, low then high byte are sent.
  - With tx_valid_h=0, only the low byte is sent, and the next load decision follows it.
- End of packet: tx_valid=0 at a load opportunity leads to 2 bits SE0, 1 bit J, then usb_tx_oen=1 and IDLE.

## Timing
- The bit strobe is the last clock of each bit period.
  - The bit counter is zeroed on IDLE→SYNC and runs modulo CLK_PER_BIT while tx_active.
- The line updates on the edge after a strobe.
  - First SYNC bit (K, usb_tx_oen=0, tx_active=1) appears one clock after tx_valid is sampled high in IDLE.
- Load opportunity: the strobe ending the last SYNC bit, the last bit of each word, or a pending stuff bit.
  - If tx_valid=1 there: tx_ready=1 for that single clock, data_in and tx_valid_h are captured, and the next bit comes from the new word.
  - If tx_valid=0 there: EOP_SE0 starts on the next bit.
- If a stuff bit is due at a word boundary, it goes out first and the load opportunity moves to the stuff bit's strobe.
- Packet length: 8 + 8·bytes + stuff bits + 3 bit periods, times CLK_PER_BIT clocks.
- tx_active falls on the edge ending EOP_J; tx_valid seen high in that same cycle is not accepted. The next packet starts no earlier than one IDLE clock later.
- Reset mid-packet: all outputs return to reset values immediately and asynchronously; no EOP is emitted.

## Structure
- usb_utm_pkg holds:
  - utm_op_mode_t.
  - Line-state constants LINE_J, LINE_K, LINE_SE0.
  - The FSM enum usb_tx_state_t.
  - SYNC_PATTERN = 8'h80.
  - STUFF_LEN = 6.
- Sub-module usb_tx_bit_enc holds the ones counter, stuff request, NRZI state and bypass mux. It advances on the bit strobe and is cleared on IDLE→SYNC.

## Test plan
- DATA_W=8, CLK_PER_BIT=4, single byte 0x00:
  - Line is KJKJKJKK JKJKJKJK SE0 SE0 J.
  - Packet lasts 76 clocks.
  - tx_ready pulses exactly once, at clock 31 after SYNC start.
- Single byte 0xFF, NORMAL mode:
  - A stuff 0 is inserted after the 5th data bit (6 ones counting SYNC).
  - Packet lasts 20 bit periods.
  - The line toggles once at the stuff bit.
- 0xFF, DISABLE_BITSTUFF_NRZI mode:
  - Data bits are 8×J with no stuff bit.
  - EOP is unchanged; total is 19 bit periods.
- DATA_W=16, words 0x3CA5 then 0x0012 with tx_valid_h=0:
  - 3 bytes are sent, A5, 3C, 12.
  - tx_ready pulses twice, spaced 16 bit periods apart.
- op_mode=NON_DRIVING with tx_valid held high for 100 clocks: usb_tx_oen stays 1, tx_ready stays 0, tx_active stays 0.
- rst asserted mid-DATA: outputs are immediately J and oen=1; after release, a new packet begins with a full SYNC.

Source files
------------

// File: rtl/usb_utm_pkg.sv
// Shared types and constants for the UTMI transmit engine: operating modes,
// line-state codes {dp, dn}, FSM states and the SYNC / bit-stuff constants.
package usb_utm_pkg;

  typedef enum logic [1:0] {
    UTM_NORMAL          = 2'd0,
    UTM_NON_DRIVING     = 2'd1,
    UTM_DIS_STUFF_NRZI  = 2'd2
  } utm_op_mode_t;

  localparam logic [1:0] LINE_J   = 2'b10;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_SE0 = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP_SE0,
    ST_EOP_J
  } usb_tx_state_t;

  localparam logic [7:0]  SYNC_PATTERN = 8'h80;
  localparam int unsigned STUFF_LEN    = 6;

endpackage

// File: rtl/usb_tx_bit_enc.sv
// Line encoder: ones counter for bit stuffing, NRZI level, and the mux that
// selects NRZI, raw (bypass), SE0 or forced J onto the registered line.
module usb_tx_bit_enc
  import usb_utm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_start,
  input  logic i_adv,
  input  logic i_bit,
  input  logic i_bypass,
  input  logic i_se0,
  input  logic i_j,
  output logic o_dp,
  output logic o_dn,
  output logic o_stuff_req
);

  logic [1:0] r_line;
  logic       r_level;
  logic [2:0] r_ones;

  logic       w_base;
  logic       w_nrzi;
  logic [2:0] w_ones_base;

  // A packet start encodes its first bit from a fresh J level and an empty run.
  assign w_base      = i_start ? 1'b1 : r_level;
  assign w_ones_base = i_start ? 3'd0 : r_ones;
  assign w_nrzi      = i_bit ? w_base : ~w_base;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_line  <= LINE_J;
      r_level <= 1'b1;
      r_ones  <= 3'd0;
    end else if (i_start || i_adv) begin
      if (i_se0) begin
        r_line <= LINE_SE0;
      end else if (i_j) begin
        r_line  <= LINE_J;
        r_level <= 1'b1;
        r_ones  <= 3'd0;
      end else if (i_bypass) begin
        r_line <= i_bit ? LINE_J : LINE_K;
        r_ones <= 3'd0;
      end else begin
        r_line  <= w_nrzi ? LINE_J : LINE_K;
        r_level <= w_nrzi;
        r_ones  <= i_bit ? w_ones_base + 3'd1 : 3'd0;
      end
    end
  end

  assign o_dp        = r_line[1];
  assign o_dn        = r_line[0];
  assign o_stuff_req = (r_ones == 3'(STUFF_LEN));

endmodule

// File: rtl/usb_utm_tx.sv
// UTMI transmit engine: accepts 8/16-bit words and serialises SYNC, data with
// bit stuffing and NRZI, and EOP onto the FS line at CLK_PER_BIT clocks per bit.
module usb_utm_tx
  import usb_utm_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int CLK_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  utm_op_mode_t      op_mode,
  input  logic [DATA_W-1:0] data_in,
  input  logic              tx_valid,
  input  logic              tx_valid_h,
  output logic              tx_ready,
  output logic              tx_active,
  output logic              usb_dp_tx,
  output logic              usb_dn_tx,
  output logic              usb_tx_oen
);

  localparam int                CNT_W     = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [DATA_W-1:0] SYNC_WORD = DATA_W'(SYNC_PATTERN);

  usb_tx_state_t     r_state;
  utm_op_mode_t      r_mode;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [4:0]        r_bits_left;

  usb_tx_state_t     w_state_nxt;
  logic [DATA_W-1:0] w_shift_nxt;
  logic [4:0]        w_bits_nxt;
  logic              w_strobe;
  logic              w_start;
  logic              w_adv;
  logic              w_bit;
  logic              w_bypass;
  logic              w_se0;
  logic              w_j;
  logic              w_ready;
  logic              w_stuff_req;

  assign w_strobe = (r_bit_cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= UTM_NORMAL;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_bits_left <= 5'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_bits_left <= w_bits_nxt;
      if (w_start)
        r_mode <= op_mode;
      if (r_state == ST_IDLE || w_strobe)
        r_bit_cnt <= '0;
      else
        r_bit_cnt <= r_bit_cnt + 1'b1;
    end
  end

  // SYNC is handled as a pre-loaded word, so SYNC and DATA share the
  // stuff / next-bit / load-opportunity priority at every strobe.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bits_nxt  = r_bits_left;
    w_start     = 1'b0;
    w_adv       = 1'b0;
    w_bit       = 1'b0;
    w_bypass    = 1'b0;
    w_se0       = 1'b0;
    w_j         = 1'b0;
    w_ready     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (tx_valid && op_mode != UTM_NON_DRIVING) begin
          w_state_nxt = ST_SYNC;
          w_start     = 1'b1;
          w_bit       = SYNC_WORD[0];
          w_shift_nxt = SYNC_WORD >> 1;
          w_bits_nxt  = 5'd7;
        end
      end
      ST_SYNC, ST_DATA: begin
        if (w_strobe) begin
          w_adv = 1'b1;
          if (w_stuff_req && r_mode != UTM_DIS_STUFF_NRZI) begin
            w_bit = 1'b0;
          end else if (r_bits_left != 5'd0) begin
            w_bit       = r_shift[0];
            w_shift_nxt = r_shift >> 1;
            w_bits_nxt  = r_bits_left - 5'd1;
            w_bypass    = (r_state == ST_DATA) && (r_mode == UTM_DIS_STUFF_NRZI);
          end else if (tx_valid) begin
            w_ready     = 1'b1;
            w_bit       = data_in[0];
            w_shift_nxt = data_in >> 1;
            w_bits_nxt  = (DATA_W == 16 && tx_valid_h) ? 5'd15 : 5'd7;
            w_state_nxt = ST_DATA;
            w_bypass    = (r_mode == UTM_DIS_STUFF_NRZI);
          end else begin
            w_se0       = 1'b1;
            w_bits_nxt  = 5'd1;
            w_state_nxt = ST_EOP_SE0;
          end
        end
      end
      ST_EOP_SE0: begin
        if (w_strobe) begin
          w_adv = 1'b1;
          if (r_bits_left != 5'd0) begin
            w_se0      = 1'b1;
            w_bits_nxt = r_bits_left - 5'd1;
          end else begin
            w_j         = 1'b1;
            w_state_nxt = ST_EOP_J;
          end
        end
      end
      ST_EOP_J: begin
        if (w_strobe) begin
          w_adv       = 1'b1;
          w_j         = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  usb_tx_bit_enc u_enc (
    .clk         (clk),
    .rst         (rst),
    .i_start     (w_start),
    .i_adv       (w_adv),
    .i_bit       (w_bit),
    .i_bypass    (w_bypass),
    .i_se0       (w_se0),
    .i_j         (w_j),
    .o_dp        (usb_dp_tx),
    .o_dn        (usb_dn_tx),
    .o_stuff_req (w_stuff_req)
  );

  assign tx_ready   = w_ready;
  assign tx_active  = (r_state != ST_IDLE);
  assign usb_tx_oen = (r_state == ST_IDLE);

endmodule

// File: tb/tb_usb_utm_tx.sv
// Testbench for usb_utm_tx: an 8-bit and a 16-bit instance driven from one
// stimulus stream, checked bit-period by bit-period against a stream-level line model.
module tb_usb_utm_tx;
  import usb_utm_pkg::*;

  localparam int CPB = 4;
  localparam logic [2:0] SYM_J   = 3'b010;
  localparam logic [2:0] SYM_K   = 3'b001;
  localparam logic [2:0] SYM_SE0 = 3'b000;

  logic         clk = 1'b0;
  logic         rst;
  utm_op_mode_t op_mode;
  logic [15:0]  data_in;
  logic         tx_valid;
  logic         tx_valid_h;
  logic         rdy16, act16, dp16, dn16, oen16;
  logic         rdy8, act8, dp8, dn8, oen8;

  int nAssert = 0;
  int nFail   = 0;

  logic [15:0] qWords[$];
  bit          qH[$];
  logic [2:0]  expSym[$];
  int          expRdy[$];

  always #5 clk = ~clk;

  usb_utm_tx #(.DATA_W(16), .CLK_PER_BIT(CPB)) dut16 (
    .clk(clk), .rst(rst), .op_mode(op_mode), .data_in(data_in),
    .tx_valid(tx_valid), .tx_valid_h(tx_valid_h), .tx_ready(rdy16),
    .tx_active(act16), .usb_dp_tx(dp16), .usb_dn_tx(dn16), .usb_tx_oen(oen16)
  );

  usb_utm_tx #(.DATA_W(8), .CLK_PER_BIT(CPB)) dut8 (
    .clk(clk), .rst(rst), .op_mode(op_mode), .data_in(data_in[7:0]),
    .tx_valid(tx_valid), .tx_valid_h(tx_valid_h), .tx_ready(rdy8),
    .tx_active(act8), .usb_dp_tx(dp8), .usb_dn_tx(dn8), .usb_tx_oen(oen8)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nAssert++;
    assert (obs === expv) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Whole-packet model: raw bit stream (SYNC + bytes LSB first), stuffing
  // after six ones, NRZI from J, then SE0 SE0 J. Ready falls on the clock
  // before the first bit of each word appears on the line.
  task automatic buildModel(input utm_op_mode_t mode);
    logic [7:0]  sp;
    logic [15:0] wd;
    bit          raw[$];
    bit          startFlag[$];
    logic        level;
    int          ones;
    int          nb;
    bit          b;
    sp = SYNC_PATTERN;
    expSym.delete();
    expRdy.delete();
    for (int i = 0; i < 8; i++) begin
      raw.push_back(sp[i]);
      startFlag.push_back(1'b0);
    end
    for (int w = 0; w < qWords.size(); w++) begin
      wd = qWords[w];
      nb = qH[w] ? 16 : 8;
      for (int i = 0; i < nb; i++) begin
        raw.push_back(wd[i]);
        startFlag.push_back(i == 0);
      end
    end
    level = 1'b1;
    ones  = 0;
    for (int r = 0; r < raw.size(); r++) begin
      b = raw[r];
      if (startFlag[r]) expRdy.push_back(CPB * expSym.size() - 1);
      if (r >= 8 && mode == UTM_DIS_STUFF_NRZI) begin
        expSym.push_back(b ? SYM_J : SYM_K);
      end else begin
        if (!b) level = ~level;
        expSym.push_back(level ? SYM_J : SYM_K);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
          level = ~level;
          expSym.push_back(level ? SYM_J : SYM_K);
          ones = 0;
        end
      end
    end
    expSym.push_back(SYM_SE0);
    expSym.push_back(SYM_SE0);
    expSym.push_back(SYM_J);
  endtask

  // Sends qWords/qH as one packet, responding to dut16's tx_ready; the 8-bit
  // instance is checked too when every word is a single byte (chk8).
  task automatic applyStimulus(input utm_op_mode_t mode, input bit chk8, input string name);
    logic [2:0]  obs16[$];
    logic [2:0]  obs8[$];
    int          rq16[$];
    int          rq8[$];
    int          len16, len8, cyc, idx;
    bit          pend;
    logic [31:0] o;
    buildModel(mode);
    @(negedge clk);
    op_mode    = mode;
    idx        = 0;
    data_in    = qWords[0];
    tx_valid_h = qH[0];
    tx_valid   = 1'b1;
    cyc = 0;
    while (!act16 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput($sformatf("%s start", name), 32'(act16), 32'd1);
    len16 = -1;
    len8  = -1;
    cyc   = 0;
    while (cyc < 3000) begin
      if (!act16 && len16 < 0) len16 = cyc;
      if (!act8 && len8 < 0) len8 = cyc;
      if (len16 >= 0 && (!chk8 || len8 >= 0)) break;
      if (act16 && cyc % CPB == 1) obs16.push_back({oen16, dp16, dn16});
      if (act8 && cyc % CPB == 1) obs8.push_back({oen8, dp8, dn8});
      pend = rdy16;
      if (rdy16) rq16.push_back(cyc);
      if (rdy8) rq8.push_back(cyc);
      @(posedge clk);
      #1;
      if (pend) begin
        idx++;
        if (idx < qWords.size()) begin
          data_in    = qWords[idx];
          tx_valid_h = qH[idx];
        end else begin
          tx_valid = 1'b0;
          data_in  = 16'($urandom);
        end
      end
      @(negedge clk);
      cyc++;
    end
    tx_valid = 1'b0;
    checkOutput($sformatf("%s len16", name), 32'(len16), 32'(CPB * expSym.size()));
    for (int k = 0; k < expSym.size(); k++) begin
      o = (k < obs16.size()) ? 32'(obs16[k]) : 'x;
      checkOutput($sformatf("%s line16[%0d]", name, k), o, 32'(expSym[k]));
    end
    checkOutput($sformatf("%s nready16", name), 32'(rq16.size()), 32'(expRdy.size()));
    for (int k = 0; k < expRdy.size(); k++) begin
      o = (k < rq16.size()) ? 32'(rq16[k]) : 'x;
      checkOutput($sformatf("%s ready16[%0d]", name, k), o, 32'(expRdy[k]));
    end
    if (chk8) begin
      checkOutput($sformatf("%s len8", name), 32'(len8), 32'(CPB * expSym.size()));
      for (int k = 0; k < expSym.size(); k++) begin
        o = (k < obs8.size()) ? 32'(obs8[k]) : 'x;
        checkOutput($sformatf("%s line8[%0d]", name, k), o, 32'(expSym[k]));
      end
      checkOutput($sformatf("%s nready8", name), 32'(rq8.size()), 32'(expRdy.size()));
      for (int k = 0; k < expRdy.size(); k++) begin
        o = (k < rq8.size()) ? 32'(rq8[k]) : 'x;
        checkOutput($sformatf("%s ready8[%0d]", name, k), o, 32'(expRdy[k]));
      end
    end else begin
      cyc = 0;
      while (act8 && cyc < 3000) begin
        @(negedge clk);
        cyc++;
      end
      checkOutput($sformatf("%s dut8 idle", name), 32'(act8), 32'd0);
    end
    checkOutput($sformatf("%s idle line16", name), 32'({oen16, dp16, dn16}), 32'h6);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bad16;
    int bad8;
    int n;
    utm_op_mode_t m;
    rst        = 1'b0;
    op_mode    = UTM_NORMAL;
    data_in    = 16'h0000;
    tx_valid   = 1'b0;
    tx_valid_h = 1'b0;
    #12;
    checkOutput("reset16", 32'({act16, rdy16, oen16, dp16, dn16}), 32'b00110);
    checkOutput("reset8",  32'({act8,  rdy8,  oen8,  dp8,  dn8}),  32'b00110);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    qWords = '{16'h0000}; qH = '{1'b0};
    applyStimulus(UTM_NORMAL, 1'b1, "byte00");
    qWords = '{16'h00FF}; qH = '{1'b0};
    applyStimulus(UTM_NORMAL, 1'b1, "byteFF");
    qWords = '{16'h00FF}; qH = '{1'b0};
    applyStimulus(UTM_DIS_STUFF_NRZI, 1'b1, "byteFF raw");
    qWords = '{16'h3CA5, 16'h0012}; qH = '{1'b1, 1'b0};
    applyStimulus(UTM_NORMAL, 1'b0, "words16");
    qWords = '{16'h00FC, 16'h003F}; qH = '{1'b0, 1'b0};
    applyStimulus(UTM_NORMAL, 1'b1, "stuff at boundary");

    @(negedge clk);
    op_mode  = UTM_NON_DRIVING;
    tx_valid = 1'b1;
    bad16 = 0;
    bad8  = 0;
    repeat (100) begin
      @(negedge clk);
      if (oen16 !== 1'b1 || rdy16 !== 1'b0 || act16 !== 1'b0) bad16++;
      if (oen8 !== 1'b1 || rdy8 !== 1'b0 || act8 !== 1'b0) bad8++;
    end
    tx_valid = 1'b0;
    checkOutput("nondriving16", 32'(bad16), 32'd0);
    checkOutput("nondriving8",  32'(bad8),  32'd0);

    for (int p = 0; p < 6; p++) begin
      n = $urandom_range(1, 3);
      qWords.delete();
      qH.delete();
      for (int i = 0; i < n; i++) begin
        qWords.push_back(($urandom_range(0, 2) == 0) ? 16'h00FF : 16'($urandom_range(0, 255)));
        qH.push_back(1'b0);
      end
      m = ($urandom_range(0, 1) == 0) ? UTM_NORMAL : UTM_DIS_STUFF_NRZI;
      applyStimulus(m, 1'b1, $sformatf("rand8 #%0d", p));
    end
    for (int p = 0; p < 4; p++) begin
      n = $urandom_range(1, 3);
      qWords.delete();
      qH.delete();
      for (int i = 0; i < n; i++) begin
        qWords.push_back(($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'($urandom));
        qH.push_back(1'($urandom_range(0, 1)));
      end
      m = ($urandom_range(0, 1) == 0) ? UTM_NORMAL : UTM_DIS_STUFF_NRZI;
      applyStimulus(m, 1'b0, $sformatf("rand16 #%0d", p));
    end

    @(negedge clk);
    op_mode  = UTM_NORMAL;
    data_in  = 16'h0000;
    tx_valid = 1'b1;
    n = 0;
    while (!act16 && n < 10) begin
      @(negedge clk);
      n++;
    end
    repeat (44) @(negedge clk);
    checkOutput("pre-reset active", 32'({act16, oen16}), 32'b10);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midreset16", 32'({act16, rdy16, oen16, dp16, dn16}), 32'b00110);
    checkOutput("midreset8",  32'({act8,  rdy8,  oen8,  dp8,  dn8}),  32'b00110);
    tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    qWords = '{16'h005A}; qH = '{1'b0};
    applyStimulus(UTM_NORMAL, 1'b1, "after reset");

    $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
    $finish;
  end

endmodule
